// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode field position and fetch state encoding for the 16-bit core
package cpu_pkg;
    localparam int PC_W = 4;
    localparam int INSTR_W = 16;
    localparam logic [3:0] HALT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    typedef enum logic {RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: valid/ready pipeline register with a flush that wins over load and drain
module if_id_reg #(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          drain,
    input  logic          flush,
    input  logic [DW-1:0] d,
    output logic          valid,
    output logic [DW-1:0] q
);
    // payload only changes on load, so a stalled entry stays stable for the consumer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q <= d;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, halt/redirect control and IF/ID handoff to decode
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int PC_W = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [3:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [PC_W-1:0]    pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);
    fetch_state_e state;
    logic advance;
    logic drain;
    logic is_halt;
    logic [INSTR_W+PC_W-1:0] id_q;

    assign drain = id_valid && id_ready;
    assign advance = state == RUN && fetch_en && !redirect_valid && (!id_valid || id_ready);
    assign is_halt = instr_in[OP_HI:OP_LO] == HALT_OPCODE;
    assign {id_instr, id_pc} = id_q;

    if_id_reg #(.DW(INSTR_W + PC_W)) u_if_id (
        .clk   (clk),
        .reset (reset),
        .load  (advance),
        .drain (drain),
        .flush (redirect_valid),
        .d     ({instr_in, pc_out}),
        .valid (id_valid),
        .q     (id_q)
    );

    // redirect overrides everything; a fetched halt is delivered but freezes the PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out <= '0;
            state <= RUN;
            halted <= 1'b0;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            pc_out <= redirect_pc;
            state <= RUN;
            halted <= 1'b0;
        end else if (advance) begin
            fetch_count <= &fetch_count ? fetch_count : fetch_count + CNT_W'(1);
            state <= is_halt ? HALTED : RUN;
            halted <= is_halt;
            pc_out <= is_halt ? pc_out : pc_out + PC_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard monitor on the IF/ID handshake
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fetch_en = 1'b0;
    logic id_ready = 1'b0;
    logic redirect_valid = 1'b0;
    logic [3:0] redirect_pc = '0;
    logic [3:0] pc_out;
    logic [15:0] instr_in;
    logic id_valid;
    logic [15:0] id_instr;
    logic [3:0] id_pc;
    logic halted;
    logic [7:0] fetch_count;

    logic fetch_en2 = 1'b0;
    logic [3:0] pc_out2;
    logic [15:0] instr_in2;
    logic id_valid2;
    logic [15:0] id_instr2;
    logic [3:0] id_pc2;
    logic halted2;
    logic [1:0] fetch_count2;

    logic [15:0] mem [16];
    logic [19:0] exp_q [$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign instr_in = mem[pc_out];
    assign instr_in2 = {4'h1, 8'h00, pc_out2};

    fetch_stage dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_out(pc_out), .instr_in(instr_in),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en2), .pc_out(pc_out2), .instr_in(instr_in2),
        .id_valid(id_valid2), .id_ready(1'b1), .id_instr(id_instr2), .id_pc(id_pc2),
        .redirect_valid(1'b0), .redirect_pc(4'h0), .halted(halted2),
        .fetch_count(fetch_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // every instruction decode accepts must be the next one the stimulus predicted
    initial begin
        forever begin
            @(negedge clk);
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_drain", {12'h0, id_instr, id_pc}, 32'hFFFFFFFF);
                end else begin
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    chk("sb_instr", {16'h0, id_instr}, {16'h0, e[19:4]});
                    chk("sb_pc", {28'h0, id_pc}, {28'h0, e[3:0]});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h2000 + 16'(i);
        mem[0] = 16'h1234; mem[1] = 16'h2452; mem[2] = 16'h3678; mem[3] = 16'h4891;
        mem[4] = 16'h7777; mem[9] = 16'h5A5A; mem[15] = 16'h0001;
        repeat (2) step();
        @(negedge clk);
        chk("rst_valid", {31'h0, id_valid}, 0);
        chk("rst_instr", {16'h0, id_instr}, 0);
        chk("rst_pc", {28'h0, id_pc}, 0);
        chk("rst_halted", {31'h0, halted}, 0);
        chk("rst_count", {24'h0, fetch_count}, 0);
        chk("rst_pc_out", {28'h0, pc_out}, 0);
        chk("rst_count2", {30'h0, fetch_count2}, 0);
        // free run
        for (int i = 0; i < 4; i++) exp_q.push_back({mem[i], 4'(i)});
        reset = 1'b1; fetch_en = 1'b1; id_ready = 1'b1; fetch_en2 = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("run_count", {24'h0, fetch_count}, 4);
        chk("run_pc_out", {28'h0, pc_out}, 4);
        chk("run_valid", {31'h0, id_valid}, 1);
        chk("sat_count2", {30'h0, fetch_count2}, 3);
        fetch_en = 1'b0;
        step();
        @(negedge clk);
        chk("drain_valid", {31'h0, id_valid}, 0);
        chk("drain_count", {24'h0, fetch_count}, 4);
        // stall on 2452
        redirect_valid = 1'b1; redirect_pc = 4'd1; fetch_en = 1'b1; id_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_instr", {16'h0, id_instr}, 32'h2452);
            chk("stall_pc", {28'h0, id_pc}, 1);
            chk("stall_pc_out", {28'h0, pc_out}, 2);
            chk("stall_count", {24'h0, fetch_count}, 5);
            step();
        end
        exp_q.push_back({16'h2452, 4'd1});
        id_ready = 1'b1;
        step();
        // redirect while stalled flushes the wrong-path entry
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 4'd9;
        @(negedge clk);
        chk("resume_instr", {16'h0, id_instr}, 32'h3678);
        chk("resume_pc", {28'h0, id_pc}, 2);
        chk("resume_count", {24'h0, fetch_count}, 6);
        step();
        redirect_valid = 1'b0; id_ready = 1'b1;
        exp_q.push_back({16'h5A5A, 4'd9});
        @(negedge clk);
        chk("flush_valid", {31'h0, id_valid}, 0);
        chk("redir_pc_out", {28'h0, pc_out}, 9);
        step();
        fetch_en = 1'b0;
        step();
        @(negedge clk);
        chk("redir_count", {24'h0, fetch_count}, 7);
        chk("redir_idle", {31'h0, id_valid}, 0);
        chk("sat_hold2", {30'h0, fetch_count2}, 3);
        // wrap 15 -> 0 into a halt
        mem[0] = 16'hF000;
        exp_q.push_back({16'h0001, 4'd15});
        exp_q.push_back({16'hF000, 4'd0});
        redirect_valid = 1'b1; redirect_pc = 4'd15; fetch_en = 1'b1;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_flag", {31'h0, halted}, 1);
            chk("halt_pc_out", {28'h0, pc_out}, 0);
            chk("halt_count", {24'h0, fetch_count}, 9);
            chk("halt_valid", {31'h0, id_valid}, 0);
            step();
        end
        exp_q.push_back({16'h7777, 4'd4});
        redirect_valid = 1'b1; redirect_pc = 4'd4;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("unhalt_flag", {31'h0, halted}, 0);
        chk("unhalt_pc_out", {28'h0, pc_out}, 4);
        step();
        fetch_en = 1'b0;
        step();
        @(negedge clk);
        chk("unhalt_count", {24'h0, fetch_count}, 10);
        // async reset with an entry held
        fetch_en = 1'b1; id_ready = 1'b0;
        step();
        fetch_en = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'h0, id_valid}, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", {31'h0, id_valid}, 0);
        chk("arst_halted", {31'h0, halted}, 0);
        chk("arst_count", {24'h0, fetch_count}, 0);
        chk("arst_pc_out", {28'h0, pc_out}, 0);
        chk("arst_instr", {16'h0, id_instr}, 0);
        @(negedge clk);
        chk("sb_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
